// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with write-to-read bypass and a
// per-register busy scoreboard that tracks pending producers for hazard detection.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rs_data,
  output logic [NUM_RD-1:0]        o_rs_busy,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic [DATA_W-1:0]        i_rd_data,
  input  logic                     i_rd_wren,
  input  logic                     i_alloc_valid,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  output logic [ADDR_W:0]          o_busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  logic wr_eff_s;
  logic alloc_eff_s;
  logic cnt_inc_s;
  logic cnt_dec_s;

  // With a hardwired x0, writes and allocations to register 0 have no effect at all.
  assign wr_eff_s    = i_rd_wren && !((ZERO_REG != 0) && (i_rd_addr == '0));
  assign alloc_eff_s = i_alloc_valid && !((ZERO_REG != 0) && (i_alloc_addr == '0));

  // Next busy vector: alloc sets, writeback clears, alloc wins on the same address.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = (alloc_eff_s && (i_alloc_addr == ADDR_W'(i))) ? 1'b1 :
                  (wr_eff_s && (i_rd_addr == ADDR_W'(i)))       ? 1'b0 :
                  busy_q[i];
    end
  end

  // The count moves by at most one per cycle, so it tracks the popcount of busy_q exactly.
  assign cnt_inc_s = alloc_eff_s && !busy_q[i_alloc_addr];
  assign cnt_dec_s = wr_eff_s && busy_q[i_rd_addr] &&
                     !(alloc_eff_s && (i_alloc_addr == i_rd_addr));

  // Busy counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc_s && !cnt_dec_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (cnt_dec_s && !cnt_inc_s) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Register array, scoreboard and counter state; reset overrides write and alloc.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_eff_s) begin
        regs_q[i_rd_addr] <= i_rd_data;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_busy_cnt = cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic              zero_s;
    logic              hit_s;

    assign addr_s = i_rs_addr[k*ADDR_W +: ADDR_W];
    assign zero_s = (ZERO_REG != 0) && (addr_s == '0);
    assign hit_s  = (BYPASS != 0) && wr_eff_s && (addr_s == i_rd_addr);

    assign o_rs_data[k*DATA_W +: DATA_W] = zero_s ? '0 :
                                           hit_s  ? i_rd_data : regs_q[addr_s];
    // A producer writing back this cycle is already visible, so the port is not stalled.
    assign o_rs_busy[k] = busy_q[addr_s] & ~hit_s & ~zero_s;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a bypassing instance and a non-bypassing
// instance driven by the same stimulus, checked against hand-computed values.
module tb_regfile_mp_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [63:0] rs_data_nb;
  logic [1:0]  rs_busy;
  logic [1:0]  rs_busy_nb;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wren;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic [5:0]  busy_cnt;
  logic [5:0]  busy_cnt_nb;

  int errors;
  int checks;

  regfile_mp_sb #(.BYPASS(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_rs_addr(rs_addr), .o_rs_data(rs_data),
    .o_rs_busy(rs_busy), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_rd_wren(rd_wren), .i_alloc_valid(alloc_valid), .i_alloc_addr(alloc_addr),
    .o_busy_cnt(busy_cnt)
  );

  regfile_mp_sb #(.BYPASS(0)) dut_nb (
    .i_clk(clk), .i_reset(rst), .i_rs_addr(rs_addr), .o_rs_data(rs_data_nb),
    .o_rs_busy(rs_busy_nb), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_rd_wren(rd_wren), .i_alloc_valid(alloc_valid), .i_alloc_addr(alloc_addr),
    .o_busy_cnt(busy_cnt_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rd_wren = 1'b0; alloc_valid = 1'b0;
    rd_addr = 5'd0; rd_data = 32'd0; alloc_addr = 5'd0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle();
    rs_addr = 10'd0;

    // Reset with a write and an alloc pending: reset must win.
    rst = 1'b1; rd_wren = 1'b1; rd_addr = 5'd5; rd_data = 32'hFFFF_FFFF;
    alloc_valid = 1'b1; alloc_addr = 5'd6;
    step();
    idle();
    #1;
    for (int a = 0; a < 32; a++) begin
      rs_addr = {5'(31 - a), 5'(a)};
      #1;
      chk("reset_data", rs_data, 64'd0);
      chk("reset_busy", {62'd0, rs_busy}, 64'd0);
    end
    chk("reset_cnt", {58'd0, busy_cnt}, 64'd0);

    // Write x5 with rs0=5 in the same cycle: bypass vs stored value.
    rs_addr = {5'd0, 5'd5};
    rd_wren = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD_BEEF;
    #1;
    chk("bypass_same_cycle", {32'd0, rs_data[31:0]}, 64'h0000_0000_DEAD_BEEF);
    chk("nobypass_same_cycle", {32'd0, rs_data_nb[31:0]}, 64'd0);
    step();
    idle();
    #1;
    chk("bypass_next_cycle", {32'd0, rs_data[31:0]}, 64'h0000_0000_DEAD_BEEF);
    chk("nobypass_next_cycle", {32'd0, rs_data_nb[31:0]}, 64'h0000_0000_DEAD_BEEF);

    // Write and alloc x0: stays zero, never busy, count unchanged.
    rs_addr = {5'd0, 5'd0};
    rd_wren = 1'b1; rd_addr = 5'd0; rd_data = 32'h0000_1234;
    alloc_valid = 1'b1; alloc_addr = 5'd0;
    #1;
    chk("x0_data_same", rs_data, 64'd0);
    step();
    idle();
    #1;
    chk("x0_data_next", rs_data, 64'd0);
    chk("x0_busy", {62'd0, rs_busy}, 64'd0);
    chk("x0_cnt", {58'd0, busy_cnt}, 64'd0);

    // Alloc x7: busy visible only from the next cycle.
    rs_addr = {5'd7, 5'd0};
    alloc_valid = 1'b1; alloc_addr = 5'd7;
    #1;
    chk("alloc_busy_same_cycle", {62'd0, rs_busy}, 64'd0);
    step();
    idle();
    #1;
    chk("alloc_busy_x7", {62'd0, rs_busy}, 64'd2);
    chk("alloc_cnt_x7", {58'd0, busy_cnt}, 64'd1);

    // Writeback x7: bypass clears busy in the same cycle; non-bypass still busy.
    rd_wren = 1'b1; rd_addr = 5'd7; rd_data = 32'h0000_0055;
    #1;
    chk("wb_busy_bypass", {62'd0, rs_busy}, 64'd0);
    chk("wb_busy_nobypass", {62'd0, rs_busy_nb}, 64'd2);
    chk("wb_data_bypass", {32'd0, rs_data[63:32]}, 64'h55);
    chk("wb_cnt_same_cycle", {58'd0, busy_cnt}, 64'd1);
    step();
    idle();
    #1;
    chk("wb_cnt_next", {58'd0, busy_cnt}, 64'd0);
    chk("wb_data_next", {32'd0, rs_data[63:32]}, 64'h55);
    chk("wb_busy_next_nb", {62'd0, rs_busy_nb}, 64'd0);

    // Alloc and write x9 together: data stored, alloc wins the busy bit.
    rd_wren = 1'b1; rd_addr = 5'd9; rd_data = 32'hA5A5_0009;
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    step();
    idle();
    rs_addr = {5'd9, 5'd9};
    #1;
    chk("x9_data", rs_data, 64'hA5A5_0009_A5A5_0009);
    chk("x9_busy", {62'd0, rs_busy}, 64'd3);
    chk("x9_cnt", {58'd0, busy_cnt}, 64'd1);

    // Alloc x3, x4, then x3 again (already busy: no count change).
    alloc_valid = 1'b1; alloc_addr = 5'd3;
    step();
    alloc_addr = 5'd4;
    step();
    chk("cnt_after_x3_x4", {58'd0, busy_cnt}, 64'd3);
    alloc_addr = 5'd3;
    step();
    idle();
    #1;
    chk("cnt_realloc_x3", {58'd0, busy_cnt}, 64'd3);

    // Write x4 while allocating x11: one clear, one set, count holds.
    rd_wren = 1'b1; rd_addr = 5'd4; rd_data = 32'h0000_0444;
    alloc_valid = 1'b1; alloc_addr = 5'd11;
    step();
    idle();
    rs_addr = {5'd11, 5'd4};
    #1;
    chk("swap_busy", {62'd0, rs_busy}, 64'd2);
    chk("swap_cnt", {58'd0, busy_cnt}, 64'd3);
    chk("swap_data_x4", {32'd0, rs_data[31:0]}, 64'h444);

    // Write to a non-busy register: stored, busy stays 0, count unchanged.
    rd_wren = 1'b1; rd_addr = 5'd10; rd_data = 32'h1010_1010;
    step();
    idle();
    rs_addr = {5'd3, 5'd10};
    #1;
    chk("nonbusy_data", {32'd0, rs_data[31:0]}, 64'h1010_1010);
    chk("nonbusy_busy", {62'd0, rs_busy}, 64'd2);
    chk("nonbusy_cnt", {58'd0, busy_cnt}, 64'd3);

    // Reset with a write to x3 in the same cycle.
    rst = 1'b1; rd_wren = 1'b1; rd_addr = 5'd3; rd_data = 32'h0000_0077;
    step();
    idle();
    rs_addr = {5'd9, 5'd3};
    #1;
    chk("rst2_data", rs_data, 64'd0);
    chk("rst2_busy", {62'd0, rs_busy}, 64'd0);
    chk("rst2_cnt", {58'd0, busy_cnt}, 64'd0);
    chk("rst2_cnt_nb", {58'd0, busy_cnt_nb}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
